// File: rtl/dma_cmd_scheduler.sv
// Round-robin command scheduler in front of dma_control: grants one of NREQ sources,
// splits its request into chunks of at most MAX_SECTORS sectors and issues them in order.
module dma_cmd_scheduler #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned MAX_SECTORS = 256,
    parameter int unsigned TIMEOUT     = 2**20
) (
    input  logic                sclk,
    input  logic                rstn,
    input  logic [NREQ-1:0]     req_val,
    input  logic [NREQ*25-1:0]  req_addr,
    input  logic [NREQ*32-1:0]  req_lba,
    input  logic [NREQ*32-1:0]  req_cnt,
    input  logic [NREQ-1:0]     req_type,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic                dma_start,
    input  logic                dma_accepted,
    input  logic                dma_done,
    output logic [24:0]         dma_mem_address,
    output logic [31:0]         dma_lba,
    output logic [31:0]         dma_sector_cnt,
    output logic                dma_type,
    output logic                busy,
    output logic [2:0]          cur_req
);
    localparam int unsigned   TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   MAX_CHUNK  = 32'(MAX_SECTORS);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t         state;
    logic [2:0]     last_grant;
    logic [31:0]    remaining;
    logic [TW-1:0]  timer;
    logic [2:0]     grant;
    logic           grant_val;
    logic [3:0]     cand;
    logic [24:0]    sel_addr;
    logic [31:0]    sel_lba;
    logic [31:0]    sel_cnt;
    logic           sel_type;
    logic [31:0]    rem_next;
    logic           timed_out;

    function automatic logic [31:0] chunk_of(input logic [31:0] r);
        return (r > MAX_CHUNK) ? MAX_CHUNK : r;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < NREQ; j++)
            if (idx == 3'(j)) v[j] = 1'b1;
        return v;
    endfunction

    // Candidates are visited starting just after last_grant, wrapping modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_val = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, last_grant} + 4'd1 + 4'(k);
            if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
            for (int unsigned j = 0; j < NREQ; j++)
                if (!grant_val && cand == 4'(j) && req_val[j]) begin
                    grant     = 3'(j);
                    grant_val = 1'b1;
                end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_lba  = '0;
        sel_cnt  = '0;
        sel_type = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++)
            if (grant == 3'(j)) begin
                sel_addr = req_addr[j*25 +: 25];
                sel_lba  = req_lba[j*32 +: 32];
                sel_cnt  = req_cnt[j*32 +: 32];
                sel_type = req_type[j];
            end
    end

    always_comb begin
        req_ack = '0;
        if (rstn && state == IDLE && grant_val) req_ack = onehot(grant);
    end

    assign rem_next  = remaining - dma_sector_cnt;
    assign timed_out = (timer == TIMER_LAST);

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state           <= IDLE;
            last_grant      <= 3'(NREQ - 1);
            remaining       <= '0;
            timer           <= '0;
            req_done        <= '0;
            req_err         <= '0;
            dma_start       <= 1'b0;
            dma_mem_address <= '0;
            dma_lba         <= '0;
            dma_sector_cnt  <= '0;
            dma_type        <= 1'b0;
            busy            <= 1'b0;
            cur_req         <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    if (grant_val) begin
                        cur_req         <= grant;
                        dma_mem_address <= sel_addr;
                        dma_lba         <= sel_lba;
                        dma_type        <= sel_type;
                        timer           <= '0;
                        busy            <= 1'b1;
                        if (sel_cnt == '0) begin
                            state     <= DONE;
                            remaining <= '0;
                            req_done  <= onehot(grant);
                        end else begin
                            state          <= ISSUE;
                            remaining      <= sel_cnt;
                            dma_sector_cnt <= chunk_of(sel_cnt);
                            dma_start      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    timer <= timer + TW'(1);
                    if (dma_accepted) begin
                        state     <= WAIT;
                        dma_start <= 1'b0;
                    end else if (timed_out) begin
                        state     <= ERR;
                        dma_start <= 1'b0;
                        req_err   <= onehot(cur_req);
                    end
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (dma_done) begin
                        remaining       <= rem_next;
                        dma_lba         <= dma_lba + dma_sector_cnt;
                        dma_mem_address <= dma_mem_address + {dma_sector_cnt[22:0], 2'b00};
                        if (rem_next == '0) begin
                            state    <= DONE;
                            req_done <= onehot(cur_req);
                        end else begin
                            state          <= ISSUE;
                            timer          <= '0;
                            dma_sector_cnt <= chunk_of(rem_next);
                            dma_start      <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state   <= ERR;
                        req_err <= onehot(cur_req);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_grant <= cur_req;
                end
                ERR: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_grant <= cur_req;
                    remaining  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Directed bench for dma_cmd_scheduler: table-driven single requests plus hand-written
// sequences for round-robin, timeout and mid-transfer reset.
module tb_dma_cmd_scheduler;
    logic        sclk;
    logic        rstn;
    logic [1:0]  req_val;
    logic [49:0] req_addr;
    logic [63:0] req_lba;
    logic [63:0] req_cnt;
    logic [1:0]  req_type;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic        dma_start;
    logic        dma_accepted;
    logic        dma_done;
    logic [24:0] dma_mem_address;
    logic [31:0] dma_lba;
    logic [31:0] dma_sector_cnt;
    logic        dma_type;
    logic        busy;
    logic [2:0]  cur_req;

    int tests = 0;
    int fails = 0;

    dma_cmd_scheduler #(
        .NREQ(2),
        .MAX_SECTORS(256),
        .TIMEOUT(64)
    ) dut (
        .sclk(sclk),
        .rstn(rstn),
        .req_val(req_val),
        .req_addr(req_addr),
        .req_lba(req_lba),
        .req_cnt(req_cnt),
        .req_type(req_type),
        .req_ack(req_ack),
        .req_done(req_done),
        .req_err(req_err),
        .dma_start(dma_start),
        .dma_accepted(dma_accepted),
        .dma_done(dma_done),
        .dma_mem_address(dma_mem_address),
        .dma_lba(dma_lba),
        .dma_sector_cnt(dma_sector_cnt),
        .dma_type(dma_type),
        .busy(busy),
        .cur_req(cur_req)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        int          r;
        logic [24:0] addr;
        logic [31:0] lba;
        logic [31:0] cnt;
        logic        typ;
        int          exp_chunks;
        logic [31:0] exp_end_lba;
        logic [24:0] exp_end_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int r);
        logic [1:0] v;
        v = 2'b01 << r;
        return v;
    endfunction

    task automatic load_req(input int r, input logic [24:0] a, input logic [31:0] l,
                            input logic [31:0] c, input logic t);
        req_addr[r*25 +: 25] = a;
        req_lba[r*32 +: 32]  = l;
        req_cnt[r*32 +: 32]  = c;
        req_type[r]          = t;
    endtask

    // Issues one request and plays dma_control: accept in ISSUE, done one cycle into WAIT.
    task automatic serve(input vec_t v);
        logic [31:0] rem, l, ch;
        logic [24:0] a;
        int n;
        rem = v.cnt; l = v.lba; a = v.addr; n = 0;
        @(negedge sclk);
        load_req(v.r, v.addr, v.lba, v.cnt, v.typ);
        req_val[v.r] = 1'b1;
        #1;
        check("ack", {62'd0, req_ack}, {62'd0, oh(v.r)});
        check("start_low_at_ack", {63'd0, dma_start}, 64'd0);
        @(negedge sclk);
        req_val[v.r] = 1'b0;
        check("cur_req", {61'd0, cur_req}, 64'(v.r));
        while (rem != 0 && n < 8) begin
            ch = (rem > 32'd256) ? 32'd256 : rem;
            check("chunk_start", {63'd0, dma_start}, 64'd1);
            check("chunk_cnt", {32'd0, dma_sector_cnt}, {32'd0, ch});
            check("chunk_lba", {32'd0, dma_lba}, {32'd0, l});
            check("chunk_addr", {39'd0, dma_mem_address}, {39'd0, a});
            check("chunk_type", {63'd0, dma_type}, {63'd0, v.typ});
            check("busy_active", {63'd0, busy}, 64'd1);
            dma_accepted = 1'b1;
            @(negedge sclk);
            dma_accepted = 1'b0;
            check("wait_start_low", {63'd0, dma_start}, 64'd0);
            @(negedge sclk);
            dma_done = 1'b1;
            @(negedge sclk);
            dma_done = 1'b0;
            rem = rem - ch;
            l   = l + ch;
            a   = a + 25'(ch * 4);
            n++;
        end
        check("done_pulse", {62'd0, req_done}, {62'd0, oh(v.r)});
        check("done_no_err", {62'd0, req_err}, 64'd0);
        check("done_start_low", {63'd0, dma_start}, 64'd0);
        check("end_lba", {32'd0, dma_lba}, {32'd0, v.exp_end_lba});
        check("end_addr", {39'd0, dma_mem_address}, {39'd0, v.exp_end_addr});
        check("chunk_count", 64'(n), 64'(v.exp_chunks));
        @(negedge sclk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("done_one_cycle", {62'd0, req_done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int order[4];
        int nack, ndone, errk, sawdone;

        vecs[0] = '{0, 25'h100,     32'h10,       32'd8,   1'b0, 1, 32'h18,  25'h120};
        vecs[1] = '{0, 25'h0,       32'h1000,     32'd600, 1'b1, 3, 32'h1258, 25'h960};
        vecs[2] = '{1, 25'h1FFFFF0, 32'hFFFFFFF0, 32'd256, 1'b1, 1, 32'hF0,  25'h3F0};
        vecs[3] = '{1, 25'h40,      32'h20,       32'd257, 1'b0, 2, 32'h121, 25'h444};
        vecs[4] = '{0, 25'h7,       32'h9,        32'd0,   1'b1, 0, 32'h9,   25'h7};

        rstn = 1'b0; req_val = '0; req_addr = '0; req_lba = '0; req_cnt = '0;
        req_type = '0; dma_accepted = 1'b0; dma_done = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst_start", {63'd0, dma_start}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_pulses", {58'd0, req_ack, req_done, req_err}, 64'd0);
        check("rst_cur_req", {61'd0, cur_req}, 64'd0);
        check("rst_fields", {dma_lba, dma_sector_cnt}, 64'd0);
        rstn = 1'b1;

        // Both requesters held high: grants must alternate starting with 0.
        @(negedge sclk);
        load_req(0, 25'h10, 32'h100, 32'd3, 1'b0);
        load_req(1, 25'h20, 32'h200, 32'd300, 1'b1);
        req_val = 2'b11;
        nack = 0; ndone = 0;
        for (int cyc = 0; cyc < 200 && ndone < 4; cyc++) begin
            if (nack >= 4) req_val = 2'b00;
            dma_accepted = dma_start;
            dma_done = busy && !dma_start && req_done == 2'b00 && req_err == 2'b00;
            #1;
            if (req_ack != 2'b00) begin
                if (nack < 4) order[nack] = (req_ack == 2'b10) ? 1 : 0;
                nack++;
            end
            if (req_done != 2'b00) ndone++;
            @(negedge sclk);
        end
        dma_accepted = 1'b0; dma_done = 1'b0; req_val = 2'b00;
        check("rr_acks", 64'(nack), 64'd4);
        check("rr_dones", 64'(ndone), 64'd4);
        check("rr_order0", 64'(order[0]), 64'd0);
        check("rr_order1", 64'(order[1]), 64'd1);
        check("rr_order2", 64'(order[2]), 64'd0);
        check("rr_order3", 64'(order[3]), 64'd1);
        @(negedge sclk);
        check("rr_idle", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 5; i++) serve(vecs[i]);

        // Timeout: accepted but never completed.
        @(negedge sclk);
        load_req(0, 25'h10, 32'h500, 32'd10, 1'b0);
        req_val = 2'b01;
        #1;
        check("to_ack", {62'd0, req_ack}, 64'd1);
        @(negedge sclk);
        req_val = 2'b00;
        dma_accepted = 1'b1;
        errk = -1; sawdone = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 1) dma_accepted = 1'b0;
            if (req_done != 2'b00) sawdone = 1;
            if (req_err != 2'b00) begin
                errk = k;
                break;
            end
            @(negedge sclk);
        end
        dma_accepted = 1'b0;
        check("to_latency", 64'(errk), 64'd64);
        check("to_err_vec", {62'd0, req_err}, 64'd1);
        check("to_no_done", 64'(sawdone), 64'd0);
        @(negedge sclk);
        check("to_busy_clear", {63'd0, busy}, 64'd0);
        check("to_err_one_cycle", {62'd0, req_err}, 64'd0);

        // dma_done in the timeout cycle completes the chunk instead.
        @(negedge sclk);
        load_req(0, 25'h20, 32'h2000, 32'd300, 1'b1);
        req_val = 2'b01;
        #1;
        check("race_ack", {62'd0, req_ack}, 64'd1);
        @(negedge sclk);
        req_val = 2'b00;
        dma_accepted = 1'b1;
        @(negedge sclk);
        dma_accepted = 1'b0;
        repeat (62) @(negedge sclk);
        check("race_pre_err", {62'd0, req_err}, 64'd0);
        dma_done = 1'b1;
        @(negedge sclk);
        dma_done = 1'b0;
        check("race_no_err", {62'd0, req_err}, 64'd0);
        check("race_next_start", {63'd0, dma_start}, 64'd1);
        check("race_next_cnt", {32'd0, dma_sector_cnt}, 64'd44);
        check("race_next_lba", {32'd0, dma_lba}, 64'h2100);
        check("race_next_addr", {39'd0, dma_mem_address}, 64'h420);
        dma_accepted = 1'b1;
        @(negedge sclk);
        dma_accepted = 1'b0;
        @(negedge sclk);
        dma_done = 1'b1;
        @(negedge sclk);
        dma_done = 1'b0;
        check("race_done", {62'd0, req_done}, 64'd1);
        check("race_done_no_err", {62'd0, req_err}, 64'd0);
        @(negedge sclk);
        check("race_idle", {63'd0, busy}, 64'd0);

        // Reset while waiting on a chunk, then a stray dma_done.
        @(negedge sclk);
        load_req(1, 25'h33, 32'h77, 32'd16, 1'b0);
        req_val = 2'b10;
        #1;
        check("mr_ack", {62'd0, req_ack}, 64'd2);
        @(negedge sclk);
        req_val = 2'b00;
        dma_accepted = 1'b1;
        @(negedge sclk);
        dma_accepted = 1'b0;
        check("mr_busy_wait", {63'd0, busy}, 64'd1);
        rstn = 1'b0;
        @(negedge sclk);
        check("mr_start", {63'd0, dma_start}, 64'd0);
        check("mr_busy", {63'd0, busy}, 64'd0);
        check("mr_pulses", {58'd0, req_ack, req_done, req_err}, 64'd0);
        check("mr_cur_req", {61'd0, cur_req}, 64'd0);
        check("mr_cnt", {32'd0, dma_sector_cnt}, 64'd0);
        rstn = 1'b1;
        dma_done = 1'b1;
        @(negedge sclk);
        dma_done = 1'b0;
        check("mr_stray_done", {62'd0, req_done}, 64'd0);
        check("mr_stray_busy", {63'd0, busy}, 64'd0);
        @(negedge sclk);
        check("mr_stray_done2", {62'd0, req_done}, 64'd0);
        serve('{0, 25'h55, 32'h300, 32'd5, 1'b0, 1, 32'h305, 25'h69});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
